// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: fetch-stage signal bundle between pipeline control and the PC/F-D register block
interface fetch_pc_unit_if;
   logic        stall;
   logic        npc_valid;
   logic [31:0] npc;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic [31:0] im_instr;
   logic [31:0] F_PC;
   logic [31:0] D_PC;
   logic [31:0] D_instr;
   logic        D_valid;
   logic        D_bd;
   logic [4:0]  D_exc;
   modport master (
      output stall, npc_valid, npc, exc_req, eret_req, epc, im_instr,
      input  F_PC, D_PC, D_instr, D_valid, D_bd, D_exc
   );
   modport slave (
      input  stall, npc_valid, npc, exc_req, eret_req, epc, im_instr,
      output F_PC, D_PC, D_instr, D_valid, D_bd, D_exc
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC register and F/D pipeline register; FETCH_ADDR_CHECK_EN enables AdEL fetch checks
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter logic [31:0] EXC_HANDLER = 32'h0000_4180
`ifdef FETCH_ADDR_CHECK_EN
   ,
   parameter logic [31:0] IM_BASE     = 32'h0000_3000,
   parameter logic [31:0] IM_LIMIT    = 32'h0000_6FFC
`endif
) (
   input logic clk,
   input logic reset,
   fetch_pc_unit_if.slave bus
);
   logic [31:0] f_pc_q, f_pc_d, d_pc_q, d_pc_d, d_instr_q, d_instr_d;
   logic        d_valid_q, d_valid_d, d_bd_q, d_bd_d, fault;
   logic [4:0]  d_exc_q, d_exc_d;
`ifdef FETCH_ADDR_CHECK_EN
   assign fault = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_BASE) || (f_pc_q > IM_LIMIT);
`else
   assign fault = 1'b0;
`endif
   // next fetch PC: exception > eret > stall hold > redirect > sequential
   always_comb begin
      f_pc_d = bus.exc_req   ? EXC_HANDLER :
               bus.eret_req  ? bus.epc :
               bus.stall     ? f_pc_q :
               bus.npc_valid ? bus.npc : f_pc_q + 32'd4;
   end
   // F/D register next state: redirects squash the fetched slot, stall holds, else capture the fetch
   always_comb begin
      d_pc_d    = d_pc_q;
      d_instr_d = d_instr_q;
      d_valid_d = d_valid_q;
      d_bd_d    = d_bd_q;
      d_exc_d   = d_exc_q;
      if (bus.exc_req || bus.eret_req) begin
         d_pc_d    = bus.exc_req ? EXC_HANDLER : bus.epc;
         d_instr_d = 32'd0;
         d_valid_d = 1'b0;
         d_bd_d    = 1'b0;
         d_exc_d   = 5'd0;
      end else if (!bus.stall) begin
         d_pc_d    = f_pc_q;
         d_instr_d = fault ? 32'd0 : bus.im_instr;
         d_valid_d = 1'b1;
         d_bd_d    = bus.npc_valid;
         d_exc_d   = fault ? 5'd4 : 5'd0;
      end
   end
   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         f_pc_q    <= RESET_PC;
         d_pc_q    <= RESET_PC;
         d_instr_q <= 32'd0;
         d_valid_q <= 1'b0;
         d_bd_q    <= 1'b0;
         d_exc_q   <= 5'd0;
      end else begin
         f_pc_q    <= f_pc_d;
         d_pc_q    <= d_pc_d;
         d_instr_q <= d_instr_d;
         d_valid_q <= d_valid_d;
         d_bd_q    <= d_bd_d;
         d_exc_q   <= d_exc_d;
      end
   end
   assign bus.F_PC    = f_pc_q;
   assign bus.D_PC    = d_pc_q;
   assign bus.D_instr = d_instr_q;
   assign bus.D_valid = d_valid_q;
   assign bus.D_bd    = d_bd_q;
   assign bus.D_exc   = d_exc_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scoreboard bench for fetch_pc_unit (honours FETCH_ADDR_CHECK_EN)
module tb_fetch_pc_unit;
   typedef struct {
      logic [31:0] f_pc;
      logic [31:0] d_pc;
      logic [31:0] d_instr;
      logic        d_valid;
      logic        d_bd;
      logic [4:0]  d_exc;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;
   int   step_no = 0;
   exp_t sb[$];
   fetch_pc_unit_if bus();
   fetch_pc_unit dut (.clk(clk), .reset(reset), .bus(bus.master));
   always #5 clk = ~clk;
   function automatic logic [31:0] imem(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction
   function automatic logic addr_fault(input logic [31:0] pc);
`ifdef FETCH_ADDR_CHECK_EN
      return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
`else
      return 1'b0;
`endif
   endfunction
   assign bus.im_instr = imem(bus.F_PC);
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, req);
   endtask
   // one clock of stimulus; expected state after the edge goes to the scoreboard
   task automatic step(input logic r, input logic st, input logic nv, input logic [31:0] np,
                       input logic ex, input logic er, input logic [31:0] ep,
                       input logic [31:0] ef, input logic [31:0] edpc, input logic ev, input logic ebd);
      exp_t e;
      @(negedge clk);
      reset         = r;
      bus.stall     = st;
      bus.npc_valid = nv;
      bus.npc       = np;
      bus.exc_req   = ex;
      bus.eret_req  = er;
      bus.epc       = ep;
      e.f_pc    = ef;
      e.d_pc    = edpc;
      e.d_valid = ev;
      e.d_bd    = ebd;
      e.d_instr = (!ev || addr_fault(edpc)) ? 32'd0 : imem(edpc);
      e.d_exc   = (ev && addr_fault(edpc)) ? 5'd4 : 5'd0;
      sb.push_back(e);
   endtask
   // monitor: compare DUT state just after each edge that has an expectation
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         step_no++;
         cmp("F_PC",    bus.F_PC,    e.f_pc);
         cmp("D_PC",    bus.D_PC,    e.d_pc);
         cmp("D_instr", bus.D_instr, e.d_instr);
         cmp("D_valid", {31'd0, bus.D_valid}, {31'd0, e.d_valid});
         cmp("D_bd",    {31'd0, bus.D_bd},    {31'd0, e.d_bd});
         cmp("D_exc",   {27'd0, bus.D_exc},   {27'd0, e.d_exc});
      end
   end
   initial begin
      bus.stall = 0; bus.npc_valid = 0; bus.npc = 0;
      bus.exc_req = 0; bus.eret_req = 0; bus.epc = 0;
      //   r  st nv npc            ex er epc            F_PC           D_PC           v  bd
      step(1, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 32'h0000_3000, 0, 0);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 32'h0000_3000, 1, 0);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 32'h0000_3004, 1, 0);
      step(0, 0, 1, 32'h0000_3100, 0, 0, 32'h0,         32'h0000_3100, 32'h0000_3008, 1, 1);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3104, 32'h0000_3100, 1, 0);
      step(0, 0, 1, 32'h0000_3010, 0, 0, 32'h0,         32'h0000_3010, 32'h0000_3104, 1, 1);
      step(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3010, 32'h0000_3104, 1, 1);
      step(0, 1, 1, 32'h0000_5000, 0, 0, 32'h0,         32'h0000_3010, 32'h0000_3104, 1, 1);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3014, 32'h0000_3010, 1, 0);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3018, 32'h0000_3014, 1, 0);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_301C, 32'h0000_3018, 1, 0);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3020, 32'h0000_301C, 1, 0);
      step(0, 1, 0, 32'h0,         1, 0, 32'h0,         32'h0000_4180, 32'h0000_4180, 0, 0);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_4184, 32'h0000_4180, 1, 0);
      step(0, 0, 1, 32'h0000_5555, 0, 1, 32'h0000_3040, 32'h0000_3040, 32'h0000_3040, 0, 0);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3044, 32'h0000_3040, 1, 0);
      step(0, 0, 0, 32'h0,         1, 1, 32'h0000_3200, 32'h0000_4180, 32'h0000_4180, 0, 0);
      step(0, 0, 1, 32'h0000_3002, 0, 0, 32'h0,         32'h0000_3002, 32'h0000_4180, 1, 1);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3006, 32'h0000_3002, 1, 0);
      step(0, 0, 1, 32'h0000_7000, 0, 0, 32'h0,         32'h0000_7000, 32'h0000_3006, 1, 1);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_7004, 32'h0000_7000, 1, 0);
      step(0, 0, 1, 32'h0000_2FFC, 0, 0, 32'h0,         32'h0000_2FFC, 32'h0000_7004, 1, 1);
      step(0, 0, 1, 32'h0000_6FFC, 0, 0, 32'h0,         32'h0000_6FFC, 32'h0000_2FFC, 1, 1);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_7000, 32'h0000_6FFC, 1, 0);
      step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0000_7000, 1, 1);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 1, 0);
      step(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 1, 0);
      step(1, 1, 1, 32'h0000_3300, 0, 0, 32'h0,         32'h0000_3000, 32'h0000_3000, 0, 0);
      step(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 32'h0000_3000, 1, 0);
      repeat (3) @(negedge clk);
      n_total++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
